// File: rtl/round_key_store.sv
// Write-side store for the 15-entry round-key word bank with fill tracking and indexed readback.
// Optional slot zeroize on clear is enabled by defining ROUND_KEY_ZEROIZE_EN.
module round_key_store #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_ready_o,
    input  logic             clr_i,
    input  logic             rd_en_i,
    input  logic [3:0]       rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic [4:0]       count_o,
    output logic             full_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned SLOTS = 16;

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_FULL = 2'd1;
`ifdef ROUND_KEY_ZEROIZE_EN
    localparam logic [1:0] S_ZERO = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] slots_q [SLOTS];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_ready_q, full_q;
    logic             wr_en;
    logic             rd_ok;
`ifdef ROUND_KEY_ZEROIZE_EN
    logic [IDX_W-1:0] zidx_q, zidx_d;
    logic             zclr;
    logic             busy_q;
`endif

    // Next-state, write strobe and readback decode
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_en      = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef ROUND_KEY_ZEROIZE_EN
        zidx_d     = zidx_q;
        zclr       = 1'b0;
        rd_ok      = (state_q != S_ZERO);
`else
        rd_ok      = 1'b1;
`endif

        if (clr_i) begin
            count_d = '0;
`ifdef ROUND_KEY_ZEROIZE_EN
            state_d = S_ZERO;
            zidx_d  = '0;
`else
            state_d = S_FILL;
`endif
        end else begin
            case (state_q)
                S_FILL: begin
                    if (wr_valid_i) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        if (count_q + CNT_W'(1) == CNT_W'(DEPTH)) begin
                            state_d = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    state_d = S_FULL;
                end
`ifdef ROUND_KEY_ZEROIZE_EN
                S_ZERO: begin
                    zclr   = 1'b1;
                    zidx_d = zidx_q + IDX_W'(1);
                    if (zidx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = S_FILL;
                    end
                end
`endif
                default: begin
                    state_d = S_FILL;
                end
            endcase
        end

        // Slot being written this cycle is still >= count, so it reads back as empty
        if (rd_en_i) begin
            if (({1'b0, rd_idx_i} < count_q) && rd_ok) begin
                rd_data_d  = slots_q[rd_idx_i];
                rd_valid_d = 1'b1;
            end else begin
                rd_data_d  = '0;
                rd_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FILL;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b1;
            full_q     <= 1'b0;
`ifdef ROUND_KEY_ZEROIZE_EN
            zidx_q     <= '0;
            busy_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ready_q <= (state_d == S_FILL);
            full_q     <= (state_d == S_FULL);
`ifdef ROUND_KEY_ZEROIZE_EN
            zidx_q     <= zidx_d;
            busy_q     <= (state_d == S_ZERO);
`endif
        end
    end

    // Word bank; write and zeroize never coincide since they belong to different states
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                slots_q[count_q[IDX_W-1:0]] <= wr_data_i;
            end
`ifdef ROUND_KEY_ZEROIZE_EN
            if (zclr) begin
                slots_q[zidx_q] <= '0;
            end
`endif
        end
    end

    assign wr_ready_o = wr_ready_q;
    assign full_o     = full_q;
    assign count_o    = count_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`ifdef ROUND_KEY_ZEROIZE_EN
    assign busy_o     = busy_q;
`else
    assign busy_o     = 1'b0;
`endif

endmodule
